// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: funct3 sizes, FSM states, owners.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic { IDLE, RD_WAIT } state_t;
    typedef enum logic { OWN_C, OWN_D } owner_t;

    // 011, 110 and 111 have no load/store meaning in this memory path.
    function automatic logic f3_illegal(input logic [2:0] f3);
        return (f3[1:0] == 2'b11) || (f3 == 3'b110);
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational byte-lane formatter: store byte enables / replication, load
// extract / extend, and the misalignment check for one access.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    logic [1:0]  size;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign size = funct3[1:0];

    for (genvar i = 0; i < 4; i++) begin : g_lane
        localparam logic [1:0] LN = 2'(i);
        assign be[i] = (size == 2'b10)
                    || (size == 2'b01 && addr_lo[1] == LN[1])
                    || (size == 2'b00 && addr_lo == LN);
    end

    assign rbyte = rdata[8*addr_lo +: 8];
    assign rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        misaligned = f3_illegal(funct3)
                  || (size == 2'b01 && addr_lo[0])
                  || (size == 2'b10 && addr_lo != 2'b00);

        case (size)
            2'b00:   wdata_rep = {4{wdata[7:0]}};
            2'b01:   wdata_rep = {2{wdata[15:0]}};
            default: wdata_rep = wdata;
        endcase

        case (funct3)
            F3_B:    rdata_ext = {{24{rbyte[7]}}, rbyte};
            F3_BU:   rdata_ext = {24'h0, rbyte};
            F3_H:    rdata_ext = {{16{rhalf[15]}}, rhalf};
            F3_HU:   rdata_ext = {16'h0, rhalf};
            default: rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core C / DMA D) arbiter in front of a single-port byte-enabled data
// memory. Optional perf counters enabled by defining DMEM_ARB_PERF_EN.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DEPTH_W    = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               c_req,
    input  logic               c_we,
    input  logic [ADDR_W-1:0]  c_addr,
    input  logic [31:0]        c_wdata,
    input  logic [2:0]         c_funct3,
    output logic               c_gnt,
    output logic               c_rvalid,
    output logic [31:0]        c_rdata,
    output logic               c_err,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [31:0]        d_wdata,
    input  logic [2:0]         d_funct3,
    output logic               d_gnt,
    output logic               d_rvalid,
    output logic [31:0]        d_rdata,
    output logic               d_err,
`ifdef DMEM_ARB_PERF_EN
    output logic [31:0]        perf_c_cnt,
    output logic [31:0]        perf_d_cnt,
    output logic [31:0]        perf_stall_cnt,
`endif
    output logic               mem_en,
    output logic               mem_we,
    output logic [3:0]         mem_be,
    output logic [DEPTH_W-1:0] mem_addr,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    localparam int            CW   = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    state_t            state, state_n;
    owner_t            own_q;
    logic [2:0]        f3_q;
    logic [1:0]        lo_q;
    logic [CW-1:0]     starve_cnt;

    logic              pick_c, pick_d, ld_start;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [2:0]        sel_f3;

    logic [3:0]        wr_be;
    logic [31:0]       wr_rep, rd_ext;
    logic              wr_mis;
    logic [31:0]       unused_wr_ext, unused_rd_rep;
    logic [3:0]        unused_rd_be;
    logic              unused_rd_mis, unused_addr;

    assign unused_addr = ^{c_addr[ADDR_W-1:DEPTH_W+2], d_addr[ADDR_W-1:DEPTH_W+2]};

    // D is forced through once C has taken STARVE_MAX grants in a row while D waited.
    assign pick_d = d_req && (!c_req || starve_cnt == SMAX);
    assign pick_c = c_req && !pick_d;

    assign sel_we    = pick_d ? d_we     : c_we;
    assign sel_addr  = pick_d ? d_addr   : c_addr;
    assign sel_wdata = pick_d ? d_wdata  : c_wdata;
    assign sel_f3    = pick_d ? d_funct3 : c_funct3;

    dmem_lane_fmt u_wr_fmt (
        .funct3    (sel_f3),
        .addr_lo   (sel_addr[1:0]),
        .wdata     (sel_wdata),
        .rdata     (32'h0),
        .be        (wr_be),
        .wdata_rep (wr_rep),
        .rdata_ext (unused_wr_ext),
        .misaligned(wr_mis)
    );

    dmem_lane_fmt u_rd_fmt (
        .funct3    (f3_q),
        .addr_lo   (lo_q),
        .wdata     (32'h0),
        .rdata     (mem_rdata),
        .be        (unused_rd_be),
        .wdata_rep (unused_rd_rep),
        .rdata_ext (rd_ext),
        .misaligned(unused_rd_mis)
    );

    // Outputs are gated by rst_n so everything reads zero the moment reset asserts.
    always_comb begin
        state_n   = state;
        ld_start  = 1'b0;
        c_gnt     = 1'b0;
        d_gnt     = 1'b0;
        c_err     = 1'b0;
        d_err     = 1'b0;
        c_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        c_rdata   = 32'h0;
        d_rdata   = 32'h0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (pick_c || pick_d) begin
                        c_gnt = pick_c;
                        d_gnt = pick_d;
                        if (wr_mis) begin
                            c_err = pick_c;
                            d_err = pick_d;
                        end else begin
                            mem_en   = 1'b1;
                            mem_we   = sel_we;
                            mem_addr = sel_addr[DEPTH_W+1:2];
                            if (sel_we) begin
                                mem_be    = wr_be;
                                mem_wdata = wr_rep;
                            end else begin
                                mem_be   = 4'hF;
                                ld_start = 1'b1;
                                state_n  = RD_WAIT;
                            end
                        end
                    end
                end
                RD_WAIT: begin
                    c_rvalid = (own_q == OWN_C);
                    d_rvalid = (own_q == OWN_D);
                    c_rdata  = c_rvalid ? rd_ext : 32'h0;
                    d_rdata  = d_rvalid ? rd_ext : 32'h0;
                    state_n  = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            own_q      <= OWN_C;
            f3_q       <= 3'h0;
            lo_q       <= 2'h0;
            starve_cnt <= '0;
        end else begin
            state <= state_n;
            if (ld_start) begin
                own_q <= pick_d ? OWN_D : OWN_C;
                f3_q  <= sel_f3;
                lo_q  <= sel_addr[1:0];
            end
            if (!d_req || d_gnt)
                starve_cnt <= '0;
            else if (c_gnt && starve_cnt != SMAX)
                starve_cnt <= starve_cnt + CW'(1);
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_c_cnt     <= 32'h0;
            perf_d_cnt     <= 32'h0;
            perf_stall_cnt <= 32'h0;
        end else begin
            if (c_gnt && !c_err) perf_c_cnt <= perf_c_cnt + 32'h1;
            if (d_gnt && !d_err) perf_d_cnt <= perf_d_cnt + 32'h1;
            if ((c_req || d_req) && !(c_gnt || d_gnt))
                perf_stall_cnt <= perf_stall_cnt + 32'h1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed + random bench for dmem_arbiter against a word-array reference model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        c_req, c_we, d_req, d_we;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic [2:0]  c_funct3, d_funct3;
    logic        c_gnt, c_rvalid, c_err, d_gnt, d_rvalid, d_err;
    logic [31:0] c_rdata, d_rdata;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] perf_c_cnt, perf_d_cnt, perf_stall_cnt;
    int          stall_obs;
`endif

    int          errs = 0;
    int          checks = 0;
    int          pc_exp = 0;
    int          pd_exp = 0;
    logic [31:0] mem    [0:1023];
    logic [31:0] shadow [0:1023];

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_funct3(c_funct3),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
`ifdef DMEM_ARB_PERF_EN
        .perf_c_cnt(perf_c_cnt), .perf_d_cnt(perf_d_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory macro: byte-enabled write, 1-cycle synchronous read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always @(negedge clk) begin
        if (!rst_n) stall_obs = 0;
        else if ((c_req || d_req) && !c_gnt && !d_gnt) stall_obs++;
    end
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit bad(input logic [2:0] f, input logic [1:0] lo);
        return (f == 3 || f == 6 || f == 7) || ((f == 1 || f == 5) && lo[0]) || (f == 2 && lo != 0);
    endfunction

    function automatic logic [3:0] be_exp(input logic [2:0] f, input logic [1:0] lo);
        if (f == 0) return 4'(1 << lo);
        if (f == 1) return (lo >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] rep_exp(input logic [2:0] f, input logic [31:0] wd);
        if (f == 0) return (wd & 32'hFF) * 32'h0101_0101;
        if (f == 1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] ld_exp(input logic [31:0] w, input logic [2:0] f, input logic [1:0] lo);
        logic [31:0] v;
        v = w >> (8 * lo);
        if (f == 0 || f == 4) begin
            v = v & 32'hFF;
            if (f == 0 && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (f == 1 || f == 5) begin
            v = v & 32'hFFFF;
            if (f == 1 && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic store_model(input logic [31:0] a, input logic [2:0] f, input logic [31:0] wd);
        logic [3:0]  be;
        logic [31:0] rep;
        be  = be_exp(f, a[1:0]);
        rep = rep_exp(f, wd);
        for (int b = 0; b < 4; b++)
            if (be[b]) shadow[a[11:2]][8*b +: 8] = rep[8*b +: 8];
    endtask

    // One transaction on port p (0=C, 1=D), checked end to end.
    task automatic access(input bit p, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f);
        bit g, e;
        int n;
        @(posedge clk); #1;
        if (p) begin d_req = 1; d_we = we; d_addr = a; d_wdata = wd; d_funct3 = f; end
        else   begin c_req = 1; c_we = we; c_addr = a; c_wdata = wd; c_funct3 = f; end
        g = 0; n = 0;
        while (!g && n < 20) begin
            @(negedge clk);
            g = p ? d_gnt : c_gnt;
            if (!g) begin @(posedge clk); #1; end
            n++;
        end
        chk("gnt", 32'(g), 1);
        if (g) begin
            e = bad(f, a[1:0]);
            chk("err", 32'(p ? d_err : c_err), 32'(e));
            chk("other_gnt", 32'(p ? c_gnt : d_gnt), 0);
            chk("mem_en", 32'(mem_en), 32'(!e));
            if (!e) begin
                chk("mem_we", 32'(mem_we), 32'(we));
                chk("mem_addr", 32'(mem_addr), 32'(a[11:2]));
                chk("mem_be", 32'(mem_be), we ? 32'(be_exp(f, a[1:0])) : 32'hF);
                if (we) chk("mem_wdata", mem_wdata, rep_exp(f, wd));
            end
            @(posedge clk); #1;
            if (p) d_req = 0; else c_req = 0;
            if (!e && we) store_model(a, f, wd);
            if (!e) begin if (p) pd_exp++; else pc_exp++; end
            @(negedge clk);
            chk("rvalid", 32'(p ? d_rvalid : c_rvalid), 32'(!e && !we));
            if (!e && !we)
                chk("rdata", p ? d_rdata : c_rdata, ld_exp(shadow[a[11:2]], f, a[1:0]));
        end else begin
            if (p) d_req = 0; else c_req = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin mem[i] = 32'h0; shadow[i] = 32'h0; end
        rst_n = 0;
        c_req = 1; c_we = 0; c_addr = 0; c_wdata = 0; c_funct3 = 3'd2;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_funct3 = 3'd2;

        // Reset state, even with a request present.
        @(negedge clk);
        chk("rst_c_gnt", 32'(c_gnt), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_be", 32'(mem_be), 0);
        chk("rst_rvalid", 32'({c_rvalid, d_rvalid, c_err, d_err}), 0);
        chk("rst_rdata", c_rdata | d_rdata, 0);
        c_req = 0;
        @(posedge clk); #1 rst_n = 1;

        // Extension cases on word 0 = 8081_7F01.
        access(0, 1, 32'h0, 32'h8081_7F01, 3'd2);
        access(0, 0, 32'h1, 0, 3'd0);
        access(0, 0, 32'h2, 0, 3'd0);
        access(0, 0, 32'h2, 0, 3'd4);
        access(0, 0, 32'h2, 0, 3'd1);
        access(0, 0, 32'h0, 0, 3'd5);
        // Byte store lanes and readback.
        access(0, 1, 32'h12, 32'h0000_00AB, 3'd0);
        access(0, 0, 32'h10, 0, 3'd2);
        access(0, 1, 32'h10, 32'hCAFE_BABE, 3'd2);
        access(0, 0, 32'h10, 0, 3'd2);
        access(0, 0, 32'h11, 0, 3'd1);
        access(1, 0, 32'h13, 0, 3'd7);

        // Both ports hammer stores at the same address: C,C,C,C,D repeating.
        @(posedge clk); #1;
        c_req = 1; c_we = 1; c_addr = 32'h80; c_wdata = $urandom; c_funct3 = 3'd2;
        d_req = 1; d_we = 1; d_addr = 32'h80; d_wdata = $urandom; d_funct3 = 3'd2;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk("starve_c_gnt", 32'(c_gnt), 32'(k % 5 != 4));
            chk("starve_d_gnt", 32'(d_gnt), 32'(k % 5 == 4));
            chk("starve_wdata", mem_wdata, (k % 5 == 4) ? d_wdata : c_wdata);
            if (k % 5 == 4) shadow[32] = d_wdata; else shadow[32] = c_wdata;
            @(posedge clk); #1;
            if (k % 5 == 4) d_wdata = $urandom; else c_wdata = $urandom;
        end
        c_req = 0; d_req = 0;
        access(1, 0, 32'h80, 0, 3'd2);

        // Random single-port traffic over words 0..7.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] f;
            bit w;
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                f = 3'($urandom_range(5, 7));
                if (f == 5) f = 3'd3;
            end else if (w) begin
                f = 3'($urandom_range(0, 2));
            end else begin
                f = 3'($urandom_range(0, 4));
                if (f >= 3) f = f + 3'd1;
            end
            access(1'($urandom_range(0, 1)), w, 32'($urandom_range(0, 31)), $urandom, f);
        end

        // Reset during RD_WAIT drops the pending rvalid.
        @(posedge clk); #1;
        c_req = 1; c_we = 0; c_addr = 32'h10; c_funct3 = 3'd2;
        @(negedge clk);
        chk("pre_rst_gnt", 32'(c_gnt), 1);
        @(posedge clk); #1;
        c_req = 0;
        #1 rst_n = 0;
        #1;
        chk("async_rvalid", 32'(c_rvalid), 0);
        chk("async_rdata", c_rdata, 0);
        chk("async_mem", 32'({mem_en, mem_we, mem_be}), 0);
        @(negedge clk);
        chk("rst_no_rvalid", 32'(c_rvalid), 0);
        @(posedge clk); #1 rst_n = 1;
        pc_exp = 0; pd_exp = 0;
        access(1, 0, 32'h10, 0, 3'd2);

        access(0, 1, 32'h20, 32'h1111_2222, 3'd2);
        access(0, 1, 32'h25, 32'h0000_0077, 3'd0);
        // C load and D store together: D stalls through RD_WAIT.
        @(posedge clk); #1;
        c_req = 1; c_we = 0; c_addr = 32'h20; c_funct3 = 3'd5;
        d_req = 1; d_we = 1; d_addr = 32'h24; d_wdata = 32'h5A5A_0000; d_funct3 = 3'd1;
        @(negedge clk);
        chk("both_c_gnt", 32'({c_gnt, d_gnt}), 32'b10);
        @(posedge clk); #1 c_req = 0; pc_exp++;
        @(negedge clk);
        chk("rdwait_no_gnt", 32'({c_gnt, d_gnt}), 0);
        chk("both_c_rvalid", 32'(c_rvalid), 1);
        chk("both_c_rdata", c_rdata, ld_exp(shadow[8], 3'd5, 2'd0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("both_d_gnt", 32'(d_gnt), 1);
        chk("both_d_be", 32'(mem_be), 32'h3);
        @(posedge clk); #1 d_req = 0; pd_exp++;
        store_model(32'h24, 3'd1, 32'h5A5A_0000);
        access(0, 0, 32'h11, 0, 3'd1);
        access(1, 0, 32'h24, 0, 3'd2);
        @(negedge clk);
`ifdef DMEM_ARB_PERF_EN
        chk("perf_c", perf_c_cnt, 32'(pc_exp));
        chk("perf_d", perf_d_cnt, 32'(pd_exp));
        chk("perf_stall", perf_stall_cnt, 32'(stall_obs));
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
